// File: rtl/countdown_arb_pkg.sv
// Shared types and constants for the countdown arbiter.
// Combinational helpers only; no latency or flow control.
package countdown_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MAX_CNT_W = 32;

    // Counter reset constant: all ones across the low w bits.
    function automatic logic [MAX_CNT_W-1:0] cnt_rst_val(input int w);
        logic [MAX_CNT_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_CNT_W; i++) begin
            if (i < w) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit at or after rr_ptr, wrapping.
// Purely combinational; no backpressure.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         win_oh,
    output logic [$clog2(NUM_REQ)-1:0] win_idx,
    output logic                       any
);
    localparam int IDX_W = $clog2(NUM_REQ);

    int   k;
    logic found;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!found && req[k]) begin
                found     = 1'b1;
                win_idx   = IDX_W'(k);
                win_oh[k] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/countdown_arbiter.sv
// Round-robin sharing of one down-counter; grant at t+1, cnt=L at t+2, done at t+3+L.
// Requesters wait by holding req; dropping req aborts. COUNTDOWN_ARB_PAUSE_EN adds hold to freeze RUN.
module countdown_arbiter
    import countdown_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] load_val,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [CNT_W-1:0]         cnt
`ifdef COUNTDOWN_ARB_PAUSE_EN
    ,
    input  logic                     hold
`endif
);
    localparam int               IDX_W   = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(cnt_rst_val(CNT_W));

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   g, g_nxt, g_inc;
    logic [IDX_W-1:0]   rr_ptr, ptr_nxt, win_idx;
    logic [NUM_REQ-1:0] win_oh, gnt_nxt, done_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               any;
    logic               run_hold;

`ifdef COUNTDOWN_ARB_PAUSE_EN
    assign run_hold = hold;
`else
    assign run_hold = 1'b0;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (any)
    );

    assign g_inc = (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        ptr_nxt   = rr_ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (any) begin
                    g_nxt     = win_idx;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (!req[g]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = g_inc;
                end else begin
                    cnt_nxt   = load_val[g*CNT_W +: CNT_W];
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Abort outranks both hold and completion.
                if (!req[g]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = g_inc;
                end else if (!run_hold) begin
                    if (cnt == '0) state_nxt = DONE;
                    else           cnt_nxt   = cnt - 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                ptr_nxt   = g_inc;
            end
            default: state_nxt = IDLE;
        endcase

        gnt_nxt  = '0;
        done_nxt = '0;
        if (state == IDLE && state_nxt == LOAD) gnt_nxt = win_oh;
        else if (state_nxt == RUN)              gnt_nxt = gnt;
        if (state_nxt == DONE)                  done_nxt = gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            g      <= '0;
            rr_ptr <= '0;
            cnt    <= CNT_RST;
            gnt    <= '0;
            done   <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            g      <= g_nxt;
            rr_ptr <= ptr_nxt;
            cnt    <= cnt_nxt;
            gnt    <= gnt_nxt;
            done   <= done_nxt;
            busy   <= (state_nxt != IDLE);
        end
    end

endmodule
